// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared DVS-to-RAVENS sizes, event word layout and AER FSM states
package dvs_ravens_pkg;

    localparam int CLK_PERIOD_NS         = 1;
    localparam int CLK_PERIOD_US_DIVISOR = 1000;
    localparam int DVS_WIDTH_PXLS        = 346;
    localparam int DVS_HEIGHT_PXLS       = 260;
    localparam int DVS_X_ADDR_BITS       = 9;
    localparam int DVS_Y_ADDR_BITS       = 9;
    localparam int TIMESTAMP_US_BITS     = 48;
    localparam int EVENT_BITS            = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + TIMESTAMP_US_BITS;

    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0]   x;
        logic [DVS_Y_ADDR_BITS-1:0]   y;
        logic                         pol;
        logic [TIMESTAMP_US_BITS-1:0] ts;
    } dvs_event_t;

    typedef enum logic {
        AER_IDLE,
        AER_ACK
    } aer_state_e;

endpackage

// File: rtl/dvs_us_timebase.sv
// rtl/dvs_us_timebase.sv - microsecond timestamp from a clock prescaler, with synchronous clear
module dvs_us_timebase
    import dvs_ravens_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ts_clear,
    output logic [TIMESTAMP_US_BITS-1:0] ts_us
);

    localparam int PRE_BITS = $clog2(CLK_PERIOD_US_DIVISOR);
    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(CLK_PERIOD_US_DIVISOR - 1);

    logic [PRE_BITS-1:0]          pre_q, pre_d;
    logic [TIMESTAMP_US_BITS-1:0] ts_q, ts_d;

    always_comb begin
        pre_d = pre_q;
        ts_d  = ts_q;
        if (ts_clear) begin
            pre_d = '0;
            ts_d  = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            ts_d  = ts_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ts_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ts_q  <= ts_d;
        end
    end

    assign ts_us = ts_q;

endmodule

// File: rtl/dvs_event_timestamper.sv
// rtl/dvs_event_timestamper.sv - AER req/ack capture, range check and timestamping onto a valid/ready stream
module dvs_event_timestamper
    import dvs_ravens_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         aer_req,
    input  logic [DVS_X_ADDR_BITS-1:0]   aer_x,
    input  logic [DVS_Y_ADDR_BITS-1:0]   aer_y,
    input  logic                         aer_pol,
    output logic                         aer_ack,
    input  logic                         ts_clear,
    output logic [EVENT_BITS-1:0]        evt_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [TIMESTAMP_US_BITS-1:0] ts_us,
    output logic [DROP_CNT_BITS-1:0]     drop_cnt
);

    logic [SYNC_STAGES-1:0]   req_sync_q, req_sync_d;
    aer_state_e               state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     evt_valid_q, evt_valid_d;
    dvs_event_t               evt_q, evt_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
    logic                     req_s;
    logic                     can_load;
    logic                     in_range;

    dvs_us_timebase u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .ts_clear (ts_clear),
        .ts_us    (ts_us)
    );

    assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], aer_req};
    assign req_s      = req_sync_q[SYNC_STAGES-1];
    assign can_load   = !evt_valid_q || evt_ready;
    assign in_range   = (aer_x < DVS_X_ADDR_BITS'(DVS_WIDTH_PXLS)) &&
                        (aer_y < DVS_Y_ADDR_BITS'(DVS_HEIGHT_PXLS));

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        drop_d      = drop_q;
        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        case (state_q)
            AER_IDLE: begin
                // A full buffer leaves ack low, which stalls the camera on its own request.
                if (req_s && can_load) begin
                    if (in_range) begin
                        evt_d       = '{x: aer_x, y: aer_y, pol: aer_pol, ts: ts_us};
                        evt_valid_d = 1'b1;
                    end else if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
                    ack_d   = 1'b1;
                    state_d = AER_ACK;
                end
            end
            AER_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = AER_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = AER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q  <= '0;
            state_q     <= AER_IDLE;
            ack_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            drop_q      <= '0;
        end else begin
            req_sync_q  <= req_sync_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            drop_q      <= drop_d;
        end
    end

    assign aer_ack   = ack_q;
    assign evt_valid = evt_valid_q;
    assign evt_data  = evt_q;
    assign drop_cnt  = drop_q;

endmodule
